// File: rtl/mdio_pkg.sv
// Shared constants and types for the MDIO link poller: BMSR location, speed
// encoding, poller FSM states and the published link tuple.
package mdio_pkg;

    localparam logic [4:0] BMSR_ADDR     = 5'h01;
    localparam int         BMSR_LINK_BIT = 2;

    typedef enum logic [1:0] {
        SPEED_10M  = 2'd0,
        SPEED_100M = 2'd1,
        SPEED_1G   = 2'd2,
        SPEED_RSVD = 2'd3
    } speed_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HOST_ISSUE,
        ST_HOST_WAIT,
        ST_BMSR_ISSUE,
        ST_BMSR_WAIT,
        ST_SPD_ISSUE,
        ST_SPD_WAIT
    } state_e;

    typedef struct packed {
        logic   up;
        speed_e speed;
        logic   duplex;
    } link_t;

endpackage

// File: rtl/mdio_link_poller_if.sv
// Register-access handshake used on both sides of the poller: the host side
// (poller is slave) and the transceiver management port (poller is master).
interface mdio_link_poller_if;
    logic        reg_rd;
    logic        reg_wr;
    logic [4:0]  reg_addr;
    logic [4:0]  md_addr;
    logic [15:0] wr_data;
    logic [15:0] rd_data;
    logic        busy;

    modport master (output reg_rd, reg_wr, reg_addr, md_addr, wr_data,
                    input  rd_data, busy);
    modport slave  (input  reg_rd, reg_wr, reg_addr, md_addr, wr_data,
                    output rd_data, busy);
endinterface

// File: rtl/mdio_poll_timer.sv
// Reload down-counter that raises a sticky poll_due flag every INTERVAL
// enabled cycles; the flag is cleared when the poll sequence starts.
module mdio_poll_timer #(
    parameter int INTERVAL = 1250000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic due
);
    localparam int             CW     = $clog2(INTERVAL);
    localparam logic [CW-1:0]  RELOAD = CW'(INTERVAL - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= RELOAD;
            due <= 1'b0;
        end else begin
            if (clr) due <= 1'b0;
            // A fresh expiry outranks a same-cycle clear so no interval is lost.
            if (en) begin
                if (cnt == '0) begin
                    cnt <= RELOAD;
                    due <= 1'b1;
                end else begin
                    cnt <= cnt - 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/mdio_link_poller.sv
// Arbitrates host register accesses and periodic BMSR/speed polls onto one
// transceiver management port and publishes the resulting link status.
module mdio_link_poller
    import mdio_pkg::*;
#(
    parameter int         POLL_INTERVAL = 1250000,
    parameter logic [4:0] PHY_ADDR      = 5'd0,
    parameter logic [4:0] SPEED_REG     = 5'h11,
    parameter logic [3:0] SPEED_LSB     = 4'd14,
    parameter logic [3:0] DUPLEX_BIT    = 4'd13
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      poll_en,
    mdio_link_poller_if.slave         host,
    mdio_link_poller_if.master        phy,
    output logic                      link_up,
    output logic [1:0]                link_speed,
    output logic                      link_duplex,
    output logic                      status_valid,
    output logic                      link_change
);
    state_e      state, nxt;
    logic        pend, op_wr;
    logic [4:0]  p_addr, p_md;
    logic [15:0] p_data, rd_q;
    logic        seen_busy, done;
    logic        poll_due, poll_start;
    logic        commit;
    link_t       cur, new_link;

    mdio_poll_timer #(.INTERVAL(POLL_INTERVAL)) u_timer (
        .clk (clk),
        .rst (rst),
        .en  (poll_en),
        .clr (poll_start),
        .due (poll_due)
    );

    // Completion is the falling edge of busy after it was seen high.
    assign done = seen_busy && !phy.busy;

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            ST_IDLE: begin
                if (!phy.busy) begin
                    if (pend)                     nxt = ST_HOST_ISSUE;
                    else if (poll_due && poll_en) nxt = ST_BMSR_ISSUE;
                end
            end
            ST_HOST_ISSUE: nxt = ST_HOST_WAIT;
            ST_HOST_WAIT:  if (done) nxt = ST_IDLE;
            ST_BMSR_ISSUE: nxt = ST_BMSR_WAIT;
            ST_BMSR_WAIT:  if (done) nxt = phy.rd_data[BMSR_LINK_BIT] ? ST_SPD_ISSUE : ST_IDLE;
            ST_SPD_ISSUE:  nxt = ST_SPD_WAIT;
            ST_SPD_WAIT:   if (done) nxt = ST_IDLE;
            default:       nxt = ST_IDLE;
        endcase
    end

    assign poll_start = (state == ST_IDLE) && (nxt == ST_BMSR_ISSUE);

    // Transceiver fields follow the state so they stay stable through the wait.
    always_comb begin
        phy.reg_rd   = 1'b0;
        phy.reg_wr   = 1'b0;
        phy.reg_addr = '0;
        phy.md_addr  = '0;
        phy.wr_data  = '0;
        case (state)
            ST_HOST_ISSUE, ST_HOST_WAIT: begin
                phy.reg_rd   = (state == ST_HOST_ISSUE) && !op_wr;
                phy.reg_wr   = (state == ST_HOST_ISSUE) && op_wr;
                phy.reg_addr = p_addr;
                phy.md_addr  = p_md;
                phy.wr_data  = p_data;
            end
            ST_BMSR_ISSUE, ST_BMSR_WAIT: begin
                phy.reg_rd   = (state == ST_BMSR_ISSUE);
                phy.reg_addr = BMSR_ADDR;
                phy.md_addr  = PHY_ADDR;
            end
            ST_SPD_ISSUE, ST_SPD_WAIT: begin
                phy.reg_rd   = (state == ST_SPD_ISSUE);
                phy.reg_addr = SPEED_REG;
                phy.md_addr  = PHY_ADDR;
            end
            default: ;
        endcase
    end

    always_comb begin
        new_link = '0;
        commit   = 1'b0;
        if (done && state == ST_BMSR_WAIT && !phy.rd_data[BMSR_LINK_BIT]) begin
            commit = 1'b1;
        end else if (done && state == ST_SPD_WAIT) begin
            commit          = 1'b1;
            new_link.up     = 1'b1;
            new_link.speed  = speed_e'(phy.rd_data[SPEED_LSB +: 2]);
            new_link.duplex = phy.rd_data[DUPLEX_BIT];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend         <= 1'b0;
            op_wr        <= 1'b0;
            p_addr       <= '0;
            p_md         <= '0;
            p_data       <= '0;
            rd_q         <= '0;
            seen_busy    <= 1'b0;
            cur          <= '0;
            status_valid <= 1'b0;
            link_change  <= 1'b0;
        end else begin
            link_change <= 1'b0;
            if (!pend && (host.reg_rd || host.reg_wr)) begin
                pend   <= 1'b1;
                op_wr  <= host.reg_wr;
                p_addr <= host.reg_addr;
                p_md   <= host.md_addr;
                p_data <= host.wr_data;
            end
            if (state == ST_HOST_ISSUE || state == ST_BMSR_ISSUE || state == ST_SPD_ISSUE)
                seen_busy <= 1'b0;
            else if (phy.busy)
                seen_busy <= 1'b1;
            if (state == ST_HOST_WAIT && done) begin
                if (!op_wr) rd_q <= phy.rd_data;
                pend <= 1'b0;
            end
            if (commit) begin
                cur          <= new_link;
                status_valid <= 1'b1;
                link_change  <= status_valid && (new_link != cur);
            end
        end
    end

    assign host.rd_data = rd_q;
    assign host.busy    = pend;
    assign link_up      = cur.up;
    assign link_speed   = cur.speed;
    assign link_duplex  = cur.duplex;

endmodule

// File: tb/tb_mdio_link_poller.sv
// Directed-plus-random bench: a transceiver model with random latency logs
// every strobe; link status is predicted from the raw register values.
module tb_mdio_link_poller;
    localparam int         PI = 100;
    localparam logic [4:0] PA = 5'd4;
    localparam logic [4:0] SR = 5'h11;

    typedef struct {
        bit          wr;
        logic [4:0]  md;
        logic [4:0]  ra;
        logic [15:0] d;
        int          c;
    } txn_t;

    logic clk = 1'b0, rst = 1'b1, poll_en = 1'b0;
    logic link_up, link_duplex, status_valid, link_change;
    logic [1:0] link_speed;

    mdio_link_poller_if host_if ();
    mdio_link_poller_if phy_if ();

    mdio_link_poller #(
        .POLL_INTERVAL(PI), .PHY_ADDR(PA), .SPEED_REG(SR),
        .SPEED_LSB(4'd14), .DUPLEX_BIT(4'd13)
    ) dut (
        .clk(clk), .rst(rst), .poll_en(poll_en),
        .host(host_if), .phy(phy_if),
        .link_up(link_up), .link_speed(link_speed), .link_duplex(link_duplex),
        .status_valid(status_valid), .link_change(link_change)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0, fails = 0;

    // Transceiver model
    logic        mbusy = 1'b0;
    logic [15:0] mrd = '0;
    logic [15:0] bmsr_val = 16'h796D, spd_val = 16'h8000;
    logic [15:0] mem [32][32];
    txn_t        log_q[$];
    txn_t        cur_t;
    int          lat = 0, viol = 0;
    bit          long_lat = 1'b0, stb, stb_prev = 1'b0;

    assign phy_if.busy    = mbusy;
    assign phy_if.rd_data = mrd;

    function automatic logic [15:0] rd_model(input logic [4:0] md, input logic [4:0] ra);
        if (md == PA && ra == 5'd1) return bmsr_val;
        if (md == PA && ra == SR)   return spd_val;
        return mem[md][ra];
    endfunction

    always @(posedge clk) begin
        stb = phy_if.reg_rd || phy_if.reg_wr;
        if (stb) begin
            if (mbusy || stb_prev || (phy_if.reg_rd && phy_if.reg_wr)) viol++;
            cur_t = '{wr: phy_if.reg_wr, md: phy_if.md_addr, ra: phy_if.reg_addr,
                      d: phy_if.wr_data, c: cyc};
            log_q.push_back(cur_t);
            mbusy <= 1'b1;
            lat = long_lat ? 25 : int'($urandom_range(1, 5));
        end else if (mbusy) begin
            if (lat == 0) begin
                mbusy <= 1'b0;
                if (cur_t.wr) mem[cur_t.md][cur_t.ra] = cur_t.d;
                else          mrd <= rd_model(cur_t.md, cur_t.ra);
            end else begin
                lat--;
            end
        end
        stb_prev = stb;
    end

    // link_change pulse monitor
    int lc_hi = 0, lc_pulses = 0;
    bit lc_prev = 1'b0;
    always @(negedge clk) begin
        if (link_change) lc_hi++;
        if (link_change && !lc_prev) lc_pulses++;
        lc_prev = link_change;
    end

    // Reference: link tuple derived from raw BMSR / speed register values
    bit       ref_valid = 1'b0;
    int       ref_up = 0, ref_spd = 0, ref_dup = 0;
    int       exp_pulses = 0;

    function automatic void ref_commit(input logic [15:0] b, input logic [15:0] s);
        int up, sp, dx;
        up = (int'(b) >> 2) & 1;
        sp = up ? (int'(s) >> 14) & 3 : 0;
        dx = up ? (int'(s) >> 13) & 1 : 0;
        if (ref_valid && (up != ref_up || sp != ref_spd || dx != ref_dup)) exp_pulses++;
        ref_up = up; ref_spd = sp; ref_dup = dx;
        ref_valid = 1'b1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wait_log(input int n, input string tag);
        int k = 0;
        while (log_q.size() < n && k < 3 * PI) begin tick(1); k++; end
        check(tag, 32'(log_q.size() >= n), 32'd1);
    endtask

    task automatic wait_idle(input string tag);
        int k = 0;
        while (mbusy && k < 200) begin tick(1); k++; end
        check(tag, 32'(mbusy), 32'd0);
        tick(3);
    endtask

    task automatic host_req(input bit wr, input logic [4:0] md, input logic [4:0] ra,
                            input logic [15:0] d);
        host_if.reg_wr = wr; host_if.reg_rd = !wr;
        host_if.md_addr = md; host_if.reg_addr = ra; host_if.wr_data = d;
        tick(1);
        host_if.reg_wr = 1'b0; host_if.reg_rd = 1'b0;
    endtask

    task automatic check_link(input string tag);
        check({tag, "_up"},    32'(link_up),      32'(ref_up));
        check({tag, "_spd"},   32'(link_speed),   32'(ref_spd));
        check({tag, "_dup"},   32'(link_duplex),  32'(ref_dup));
        check({tag, "_valid"}, 32'(status_valid), 32'd1);
        check({tag, "_pulses"}, 32'(lc_pulses),   32'(exp_pulses));
    endtask

    // One autonomous poll with the given register contents
    task automatic run_poll(input logic [15:0] b, input logic [15:0] s, input string tag);
        int n;
        log_q.delete();
        bmsr_val = b; spd_val = s;
        n = b[2] ? 2 : 1;
        wait_log(n, {tag, "_reads"});
        wait_idle({tag, "_done"});
        check({tag, "_nreads"}, 32'(log_q.size()), 32'(n));
        if (log_q.size() >= n) begin
            check({tag, "_bmsr"}, {22'd0, log_q[0].wr, log_q[0].md, log_q[0].ra}, {22'd0, 1'b0, PA, 5'd1});
            if (n == 2)
                check({tag, "_spdreg"}, {22'd0, log_q[1].wr, log_q[1].md, log_q[1].ra}, {22'd0, 1'b0, PA, SR});
        end
        ref_commit(b, s);
        check_link(tag);
    endtask

    initial begin
        int s_cyc, r_cyc;
        logic [15:0] b, s, exp_rd;
        logic [4:0]  md, ra;
        int nwr;

        for (int i = 0; i < 32; i++)
            for (int j = 0; j < 32; j++)
                mem[i][j] = 16'((i * 256 + j) ^ 16'h5A00);
        mem[3][2] = 16'h0022;
        host_if.reg_rd = 1'b0; host_if.reg_wr = 1'b0;
        host_if.reg_addr = '0; host_if.md_addr = '0; host_if.wr_data = '0;

        // Reset state
        tick(3);
        check("rst_link_up", 32'(link_up), 32'd0);
        check("rst_speed", 32'(link_speed), 32'd0);
        check("rst_valid", 32'(status_valid), 32'd0);
        check("rst_change", 32'(link_change), 32'd0);
        check("rst_host_busy", 32'(host_if.busy), 32'd0);
        check("rst_phy_strobe", 32'(phy_if.reg_rd | phy_if.reg_wr), 32'd0);
        rst = 1'b0;
        poll_en = 1'b1;

        // First poll: link up at 1G half duplex, no change pulse
        run_poll(16'h796D, 16'h8000, "first");
        // Link drops: BMSR only, one-cycle pulse
        run_poll(16'h7969, 16'h8000, "drop");
        check("drop_pulse_width", 32'(lc_hi), 32'(lc_pulses));
        // Reserved speed value passes through
        run_poll(16'h0004, 16'hE000, "rsvd");
        for (int i = 0; i < 6; i++) begin
            b = 16'($urandom);
            b[2] = 1'($urandom_range(0, 1));
            s = 16'($urandom);
            run_poll(b, s, "rand");
        end

        // Host read lands on the same edge the poll timer expires
        run_poll(16'h796D, 16'h4000, "pre_collide");
        s_cyc = log_q[0].c;
        log_q.delete();
        while (cyc != s_cyc - 2 + PI) tick(1);
        host_req(1'b0, 5'd3, 5'd2, 16'h0);
        wait_log(3, "collide_reads");
        wait_idle("collide_done");
        if (log_q.size() >= 2) begin
            check("collide_host_first", {22'd0, log_q[0].wr, log_q[0].md, log_q[0].ra}, {22'd0, 1'b0, 5'd3, 5'd2});
            check("collide_poll_next", {27'd0, log_q[1].ra}, 32'd1);
            check("collide_poll_soon", 32'((log_q[1].c - log_q[0].c) <= 12), 32'd1);
        end
        check("collide_rd_data", 32'(host_if.rd_data), 32'h0022);
        check("collide_host_busy", 32'(host_if.busy), 32'd0);
        ref_commit(16'h796D, 16'h4000);
        check_link("collide");

        // Host write strobed during BMSR_WAIT waits for the speed read; second strobe dropped
        log_q.delete();
        bmsr_val = 16'h796D; spd_val = 16'h2000;
        wait_log(1, "hw_bmsr");
        host_req(1'b1, 5'd3, 5'd0, 16'h1200);
        tick(1);
        check("hw_busy_set", 32'(host_if.busy), 32'd1);
        host_req(1'b1, 5'd3, 5'd5, 16'hBEEF);
        wait_log(3, "hw_reads");
        wait_idle("hw_done");
        tick(20);
        nwr = 0;
        foreach (log_q[i]) if (log_q[i].wr) nwr++;
        check("hw_one_write", 32'(nwr), 32'd1);
        if (log_q.size() >= 3) begin
            check("hw_second_is_spd", {27'd0, log_q[1].ra}, {27'd0, SR});
            check("hw_write_fields", {log_q[2].wr, 10'd0, log_q[2].ra, log_q[2].d}, {1'b1, 10'd0, 5'd0, 16'h1200});
        end
        check("hw_busy_clear", 32'(host_if.busy), 32'd0);
        ref_commit(16'h796D, 16'h2000);
        check_link("hw");

        // Reset while the speed read is in flight
        log_q.delete();
        bmsr_val = 16'h796D; spd_val = 16'h6000;
        wait_log(1, "rr_bmsr");
        long_lat = 1'b1;
        wait_log(2, "rr_spd");
        tick(2);
        rst = 1'b1;
        r_cyc = cyc;
        tick(1);
        rst = 1'b0;
        long_lat = 1'b0;
        check("rr_link_up", 32'(link_up), 32'd0);
        check("rr_speed", 32'(link_speed), 32'd0);
        check("rr_duplex", 32'(link_duplex), 32'd0);
        check("rr_valid", 32'(status_valid), 32'd0);
        check("rr_strobe", 32'(phy_if.reg_rd | phy_if.reg_wr), 32'd0);
        ref_valid = 1'b0; ref_up = 0; ref_spd = 0; ref_dup = 0;
        log_q.delete();
        wait_log(1, "rr_resume");
        if (log_q.size() >= 1) check("rr_resume_time", 32'(log_q[0].c - r_cyc), 32'd102);
        wait_log(2, "rr_reads");
        wait_idle("rr_done");
        ref_commit(16'h796D, 16'h6000);
        check_link("rr");

        // Polling disabled: only host traffic reaches the transceiver
        poll_en = 1'b0;
        log_q.delete();
        tick(PI);
        md = 5'($urandom_range(5, 31));
        ra = 5'($urandom_range(0, 31));
        exp_rd = mem[md][ra];
        host_req(1'b0, md, ra, 16'h0);
        tick(2 * PI);
        check("pd_nstrobes", 32'(log_q.size()), 32'd1);
        if (log_q.size() >= 1)
            check("pd_host_fields", {22'd0, log_q[0].wr, log_q[0].md, log_q[0].ra}, {22'd0, 1'b0, md, ra});
        check("pd_rd_data", 32'(host_if.rd_data), 32'(exp_rd));
        check("pd_host_busy", 32'(host_if.busy), 32'd0);

        check("protocol_violations", 32'(viol), 32'd0);
        check("pulse_width_total", 32'(lc_hi), 32'(lc_pulses));
        check("pulse_count_total", 32'(lc_pulses), 32'(exp_pulses));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
